// File: rtl/axi_lite_rr_arbiter_pkg.sv
// axi_lite_arb_pkg: shared sequencer state types and limits for the AXI-Lite round-robin arbiter
package axi_lite_arb_pkg;
  localparam int MAX_SLV = 16;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_e;
endpackage

// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI_LITE: AXI-Lite bus bundle with Master/Slave views
interface AXI_LITE #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid, aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid, w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid, b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid, ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid, r_ready;
  modport Master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_prot, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
  modport Slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_prot, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_rr_arbiter_rr.sv
// rr_arbiter: round-robin pick starting after the last taken grant; pointer moves only on take
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         take,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);
  logic [W-1:0] ptr_q, ptr_d, idx;
  always_comb begin
    grant_idx = ptr_q;
    idx = ptr_q;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr_q) + k) % N);
      if (req[idx]) grant_idx = idx;
    end
    grant_valid = |req;
    ptr_d = take ? grant_idx : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? W'(N - 1) : ptr_d;
endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: N:1 AXI-Lite mux with independent round-robin read and write sequencers
module axi_lite_rr_arbiter import axi_lite_arb_pkg::*; #(
  parameter int NUM_SLV    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IW = $clog2(NUM_SLV)
) (
  input  logic     aclk,
  input  logic     areset,
  AXI_LITE.Slave   slv [NUM_SLV],
  AXI_LITE.Master  mst,
  output logic     rd_busy,
  output logic     wr_busy
);
  logic [NUM_SLV-1:0]      ar_valid_v, r_ready_v, aw_valid_v, w_valid_v, b_ready_v;
  logic [ADDR_WIDTH-1:0]   ar_addr_v [NUM_SLV];
  logic [ADDR_WIDTH-1:0]   aw_addr_v [NUM_SLV];
  logic [2:0]              ar_prot_v [NUM_SLV];
  logic [2:0]              aw_prot_v [NUM_SLV];
  logic [DATA_WIDTH-1:0]   w_data_v [NUM_SLV];
  logic [DATA_WIDTH/8-1:0] w_strb_v [NUM_SLV];
  rd_state_e               rd_state_q, rd_state_d;
  wr_state_e               wr_state_q, wr_state_d;
  logic [IW-1:0]           rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, rd_arb_idx, wr_arb_idx;
  logic                    rd_arb_valid, wr_arb_valid, rd_take, wr_take;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    ar_hs, r_hs, aw_hs, w_hs, b_hs;
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_port
    logic rd_sel, wr_sel;
    assign rd_sel = rd_gnt_q == IW'(i);
    assign wr_sel = wr_gnt_q == IW'(i);
    assign ar_valid_v[i] = slv[i].ar_valid;
    assign ar_addr_v[i]  = slv[i].ar_addr;
    assign ar_prot_v[i]  = slv[i].ar_prot;
    assign r_ready_v[i]  = slv[i].r_ready;
    assign aw_valid_v[i] = slv[i].aw_valid;
    assign aw_addr_v[i]  = slv[i].aw_addr;
    assign aw_prot_v[i]  = slv[i].aw_prot;
    assign w_valid_v[i]  = slv[i].w_valid;
    assign w_data_v[i]   = slv[i].w_data;
    assign w_strb_v[i]   = slv[i].w_strb;
    assign b_ready_v[i]  = slv[i].b_ready;
    assign slv[i].ar_ready = rd_sel && rd_state_q == RD_ADDR && mst.ar_ready;
    assign slv[i].r_valid  = rd_sel && rd_state_q == RD_DATA && mst.r_valid;
    assign slv[i].r_data   = mst.r_data;
    assign slv[i].r_resp   = mst.r_resp;
    // Ready is masked once a channel has handshaken so the requester sees exactly one acceptance
    assign slv[i].aw_ready = wr_sel && wr_state_q == WR_ADDR && !aw_done_q && mst.aw_ready;
    assign slv[i].w_ready  = wr_sel && wr_state_q == WR_ADDR && !w_done_q && mst.w_ready;
    assign slv[i].b_valid  = wr_sel && wr_state_q == WR_RESP && mst.b_valid;
    assign slv[i].b_resp   = mst.b_resp;
  end
  rr_arbiter #(.N(NUM_SLV)) u_rd_arb (
    .clk(aclk), .rst(areset), .req(ar_valid_v), .take(rd_take),
    .grant_idx(rd_arb_idx), .grant_valid(rd_arb_valid)
  );
  rr_arbiter #(.N(NUM_SLV)) u_wr_arb (
    .clk(aclk), .rst(areset), .req(aw_valid_v), .take(wr_take),
    .grant_idx(wr_arb_idx), .grant_valid(wr_arb_valid)
  );
  assign mst.ar_valid = rd_state_q == RD_ADDR && ar_valid_v[rd_gnt_q];
  assign mst.ar_addr  = ar_addr_v[rd_gnt_q];
  assign mst.ar_prot  = ar_prot_v[rd_gnt_q];
  assign mst.r_ready  = rd_state_q == RD_DATA && r_ready_v[rd_gnt_q];
  assign mst.aw_valid = wr_state_q == WR_ADDR && aw_valid_v[wr_gnt_q] && !aw_done_q;
  assign mst.aw_addr  = aw_addr_v[wr_gnt_q];
  assign mst.aw_prot  = aw_prot_v[wr_gnt_q];
  assign mst.w_valid  = wr_state_q == WR_ADDR && w_valid_v[wr_gnt_q] && !w_done_q;
  assign mst.w_data   = w_data_v[wr_gnt_q];
  assign mst.w_strb   = w_strb_v[wr_gnt_q];
  assign mst.b_ready  = wr_state_q == WR_RESP && b_ready_v[wr_gnt_q];
  assign rd_busy = rd_state_q != RD_IDLE;
  assign wr_busy = wr_state_q != WR_IDLE;
  always_comb begin
    ar_hs = mst.ar_valid && mst.ar_ready;
    r_hs = mst.r_valid && mst.r_ready;
    rd_take = rd_state_q == RD_IDLE && rd_arb_valid;
    rd_gnt_d = rd_take ? rd_arb_idx : rd_gnt_q;
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (rd_arb_valid) rd_state_d = RD_ADDR;
      RD_ADDR: if (ar_hs) rd_state_d = RD_DATA;
      RD_DATA: if (r_hs) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end
  always_comb begin
    aw_hs = mst.aw_valid && mst.aw_ready;
    w_hs = mst.w_valid && mst.w_ready;
    b_hs = mst.b_valid && mst.b_ready;
    wr_take = wr_state_q == WR_IDLE && wr_arb_valid;
    wr_gnt_d = wr_take ? wr_arb_idx : wr_gnt_q;
    aw_done_d = b_hs ? 1'b0 : aw_done_q | aw_hs;
    w_done_d = b_hs ? 1'b0 : w_done_q | w_hs;
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (wr_arb_valid) wr_state_d = WR_ADDR;
      WR_ADDR: if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      WR_RESP: if (b_hs) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_gnt_q <= '0;
      wr_gnt_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q <= rd_gnt_d;
      wr_gnt_q <= wr_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
endmodule
